// File: rtl/dpram_frame_reader.sv
// Read-side engine for a simple dual-port RAM: turns {addr, len} commands into a
// valid/ready byte stream, absorbing the 1-cycle RAM read latency in a 2-entry skid FIFO.
module dpram_frame_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    // state   | meaning
    // S_IDLE  | waiting for a command, cmd_ready high
    // S_READ  | issuing RAM reads while remaining != 0
    // S_DRAIN | last address issued, emptying in-flight read and FIFO
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] data_q1;
    logic              last_q1;
    logic [2:0]        occupancy;
    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign m_valid   = (fifo_count != 2'd0);

    // Occupancy counts reads already in flight so the FIFO can never overflow.
    always_comb begin
        accept    = cmd_valid && (state == S_IDLE);
        pop       = m_valid && m_ready;
        push      = inflight;
        occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        issue     = (state == S_READ) && (occupancy < 3'd2);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (issue && (remaining == LEN_ONE)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((fifo_count == 2'd0) && !inflight) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            ram_rd_addr   <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (accept) begin
                ram_rd_addr <= cmd_addr;
                remaining   <= (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
            end else if (issue) begin
                ram_rd_addr <= ram_rd_addr + ADDR_ONE;
                remaining   <= remaining - LEN_ONE;
            end
            inflight <= issue;
            if (issue) begin
                inflight_last <= (remaining == LEN_ONE);
            end
        end
    end

    // Two-entry FIFO; entry 0 is the head and drives the stream outputs directly.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            fifo_count <= 2'd0;
            m_data     <= '0;
            m_last     <= 1'b0;
            data_q1    <= '0;
            last_q1    <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        m_data <= ram_rd_data;
                        m_last <= inflight_last;
                    end else begin
                        data_q1 <= ram_rd_data;
                        last_q1 <= inflight_last;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    m_data     <= data_q1;
                    m_last     <= last_q1;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        m_data <= ram_rd_data;
                        m_last <= inflight_last;
                    end else begin
                        m_data  <= data_q1;
                        m_last  <= last_q1;
                        data_q1 <= ram_rd_data;
                        last_q1 <= inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_frame_reader.sv
// Randomized bench for dpram_frame_reader: a RAM model plus an expected-byte queue
// built from memory contents, compared against every stream handshake.
module tb_dpram_frame_reader;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic [9:0]  ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:1023];
    int          n_checks = 0;
    int          n_errors = 0;

    dpram_frame_reader #(.ADDR_W(10), .DATA_W(8)) dut (
        .rd_clk      (rd_clk),
        .rd_rst_n    (rd_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) ram_rd_data <= mem[ram_rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edge index k: accept edge is 0; observations at #1 after edge k.
    task automatic run_cmd(input logic [9:0] addr, input logic [10:0] len,
                           input int ready_pct, input string name);
        logic [7:0] exp_q[$];
        int   eff_len;
        int   first_valid = -1;
        int   last_hs = -1;
        int   done_cyc = -1;
        int   done_cnt = 0;
        int   last_cnt = 0;
        int   budget;
        int   w;
        bit   finished = 0;
        bit   prev_stall = 0;
        logic [7:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [7:0] exp_b;

        eff_len = (int'(len) > 1024) ? 1024 : int'(len);
        for (int i = 0; i < eff_len; i++) exp_q.push_back(mem[(int'(addr) + i) % 1024]);

        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge rd_clk); #1;
            w++;
        end
        check({name, "_ready_in"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        @(posedge rd_clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom_range(1023);
        cmd_len   = $urandom_range(2047);

        budget = eff_len * 20 + 50;
        for (int k = 0; k < budget && !finished; k++) begin
            if (k > 0) begin
                @(posedge rd_clk); #1;
            end
            if (m_valid && first_valid < 0) first_valid = k;
            if (prev_stall) begin
                check({name, "_stall_valid"}, m_valid, 1);
                check({name, "_stall_data"}, m_data, prev_data);
                check({name, "_stall_last"}, m_last, prev_last);
            end
            if (done_cyc >= 0 && k == done_cyc + 1) begin
                check({name, "_ready_back"}, cmd_ready, 1);
                check({name, "_busy_clear"}, busy, 0);
                check({name, "_done_width"}, done, 0);
                finished = 1;
            end else if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (!finished) begin
                m_ready = ($urandom_range(99) < ready_pct);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_extra_byte"}, 1, 0);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check({name, "_data"}, m_data, exp_b);
                        check({name, "_last"}, m_last, (exp_q.size() == 0));
                        last_hs = k + 1;
                    end
                    if (m_last) last_cnt++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end

        check({name, "_completed"}, finished, 1);
        check({name, "_bytes_left"}, exp_q.size(), 0);
        check({name, "_done_count"}, done_cnt, 1);
        if (eff_len > 0) begin
            check({name, "_last_count"}, last_cnt, 1);
            check({name, "_first_valid"}, first_valid, 2);
            check({name, "_done_after_last"}, done_cyc, last_hs + 1);
            if (ready_pct >= 100) check({name, "_throughput"}, last_hs, eff_len + 2);
        end else begin
            check({name, "_no_valid"}, (first_valid < 0), 1);
            check({name, "_done_soon"}, (done_cyc >= 0 && done_cyc <= 2), 1);
        end
        m_ready = 1'b0;
    endtask

    initial begin
        int hs;
        logic [9:0] a;

        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
        rd_rst_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        repeat (3) @(posedge rd_clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        rd_rst_n = 1'b1;
        @(posedge rd_clk); #1;

        run_cmd(10'h010, 11'd4, 100, "basic");
        run_cmd(10'h3FE, 11'd4, 100, "wrap");
        check("wrap_end_addr", ram_rd_addr, 10'h002);

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(255));

        run_cmd(10'($urandom_range(1023)), 11'd16, 50, "bp16");
        run_cmd(10'h155, 11'd0, 100, "len0");
        run_cmd(10'h200, 11'd1024, 100, "full");
        check("full_end_addr", ram_rd_addr, 10'h200);
        run_cmd(10'h0A0, 11'h7FF, 50, "sat");
        run_cmd(10'h3FF, 11'd1, 100, "len1");

        for (int r = 0; r < 6; r++) begin
            run_cmd(10'($urandom_range(1023)), 11'($urandom_range(40, 1)),
                    $urandom_range(90, 20), "rand");
        end

        // Reset in the middle of a 20-byte command after 5 bytes.
        a = 10'($urandom_range(1023));
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = 11'd20;
        @(posedge rd_clk); #1;
        cmd_valid = 1'b0;
        hs = 0;
        for (int k = 0; k < 60 && hs < 5; k++) begin
            m_ready = 1'b1;
            if (m_valid) begin
                check("mid_data", m_data, mem[(int'(a) + hs) % 1024]);
                hs++;
            end
            @(posedge rd_clk); #1;
        end
        check("mid_hs_count", hs, 5);
        m_ready  = 1'b0;
        rd_rst_n = 1'b0;
        @(posedge rd_clk); #1;
        rd_rst_n = 1'b1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_addr", ram_rd_addr, 0);
        run_cmd(10'h000, 11'd2, 100, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
